// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: reservation station with tag wakeup, age-matrix oldest-first select
// and a single issue register toward the functional unit.
module rs_issue_scheduler #(
   parameter  int RS_ENTRIES = 8,
   parameter  int NUM_PREGS  = 128,
   parameter  int NUM_WB     = 2,
   parameter  int PAYLOAD_W  = 38,
   localparam int TAG_W      = $clog2(NUM_PREGS),
   localparam int OCC_W      = $clog2(RS_ENTRIES) + 1,
   localparam int IDX_W      = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    disp_valid,
   output logic                    disp_ready,
   input  logic [TAG_W-1:0]        disp_src1_tag,
   input  logic [TAG_W-1:0]        disp_src2_tag,
   input  logic                    disp_src1_rdy,
   input  logic                    disp_src2_rdy,
   input  logic [TAG_W-1:0]        disp_dst_tag,
   input  logic [PAYLOAD_W-1:0]    disp_payload,
   input  logic [NUM_WB-1:0]       wb_valid,
   input  logic [NUM_WB*TAG_W-1:0] wb_tag,
   output logic                    iss_valid,
   input  logic                    iss_ready,
   output logic [TAG_W-1:0]        iss_src1_tag,
   output logic [TAG_W-1:0]        iss_src2_tag,
   output logic [TAG_W-1:0]        iss_dst_tag,
   output logic [PAYLOAD_W-1:0]    iss_payload,
   input  logic                    flush,
   output logic [OCC_W-1:0]        occupancy
);
   logic [RS_ENTRIES-1:0] valid_q, valid_d, s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d, elig, sel;
   logic [TAG_W-1:0]      s1_tag_q [RS_ENTRIES], s1_tag_d [RS_ENTRIES];
   logic [TAG_W-1:0]      s2_tag_q [RS_ENTRIES], s2_tag_d [RS_ENTRIES];
   logic [TAG_W-1:0]      dst_q    [RS_ENTRIES], dst_d    [RS_ENTRIES];
   logic [PAYLOAD_W-1:0]  pay_q    [RS_ENTRIES], pay_d    [RS_ENTRIES];
   // age_q[i][j] set means entry i was dispatched before entry j
   logic [RS_ENTRIES-1:0] age_q    [RS_ENTRIES], age_d    [RS_ENTRIES];
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  iss_valid_q, iss_valid_d;
   logic [TAG_W-1:0]      iss_s1_q, iss_s1_d, iss_s2_q, iss_s2_d, iss_dst_q, iss_dst_d;
   logic [PAYLOAD_W-1:0]  iss_pay_q, iss_pay_d;
   logic                  accept, load, fire, disp_s1_hit, disp_s2_hit;
   logic [IDX_W-1:0]      free_idx, sel_idx;

   assign disp_ready   = occ_q < OCC_W'(RS_ENTRIES);
   assign occupancy    = occ_q;
   assign iss_valid    = iss_valid_q;
   assign iss_src1_tag = iss_s1_q;
   assign iss_src2_tag = iss_s2_q;
   assign iss_dst_tag  = iss_dst_q;
   assign iss_payload  = iss_pay_q;

   always_comb begin
      valid_d     = valid_q;
      s1_rdy_d    = s1_rdy_q;
      s2_rdy_d    = s2_rdy_q;
      s1_tag_d    = s1_tag_q;
      s2_tag_d    = s2_tag_q;
      dst_d       = dst_q;
      pay_d       = pay_q;
      age_d       = age_q;
      iss_valid_d = iss_valid_q;
      iss_s1_d    = iss_s1_q;
      iss_s2_d    = iss_s2_q;
      iss_dst_d   = iss_dst_q;
      iss_pay_d   = iss_pay_q;
      accept      = disp_valid && disp_ready;
      free_idx    = '0;
      for (int i = RS_ENTRIES - 1; i >= 0; i--)
         if (!valid_q[i]) free_idx = IDX_W'(i);
      elig    = valid_q & s1_rdy_q & s2_rdy_q;
      sel     = elig;
      sel_idx = '0;
      for (int i = 0; i < RS_ENTRIES; i++)
         for (int j = 0; j < RS_ENTRIES; j++)
            if (j != i && elig[j] && !age_q[i][j]) sel[i] = 1'b0;
      for (int i = 0; i < RS_ENTRIES; i++)
         if (sel[i]) sel_idx = IDX_W'(i);
      load        = !iss_valid_q || iss_ready;
      fire        = load && |elig;
      disp_s1_hit = disp_src1_rdy;
      disp_s2_hit = disp_src2_rdy;
      for (int w = 0; w < NUM_WB; w++) begin
         if (wb_valid[w]) begin
            if (wb_tag[w*TAG_W +: TAG_W] == disp_src1_tag) disp_s1_hit = 1'b1;
            if (wb_tag[w*TAG_W +: TAG_W] == disp_src2_tag) disp_s2_hit = 1'b1;
            for (int i = 0; i < RS_ENTRIES; i++) begin
               if (wb_tag[w*TAG_W +: TAG_W] == s1_tag_q[i]) s1_rdy_d[i] = 1'b1;
               if (wb_tag[w*TAG_W +: TAG_W] == s2_tag_q[i]) s2_rdy_d[i] = 1'b1;
            end
         end
      end
      if (load) iss_valid_d = fire;
      if (fire) begin
         valid_d[sel_idx] = 1'b0;
         iss_s1_d         = s1_tag_q[sel_idx];
         iss_s2_d         = s2_tag_q[sel_idx];
         iss_dst_d        = dst_q[sel_idx];
         iss_pay_d        = pay_q[sel_idx];
      end
      // the free slot is never the selected one, so both writes can coexist
      if (accept) begin
         valid_d[free_idx]  = 1'b1;
         s1_tag_d[free_idx] = disp_src1_tag;
         s2_tag_d[free_idx] = disp_src2_tag;
         s1_rdy_d[free_idx] = disp_s1_hit;
         s2_rdy_d[free_idx] = disp_s2_hit;
         dst_d[free_idx]    = disp_dst_tag;
         pay_d[free_idx]    = disp_payload;
         for (int j = 0; j < RS_ENTRIES; j++) age_d[j][free_idx] = 1'b1;
         age_d[free_idx] = '0;
      end
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(fire);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q     <= '0;
         s1_rdy_q    <= '0;
         s2_rdy_q    <= '0;
         occ_q       <= '0;
         iss_valid_q <= 1'b0;
         iss_s1_q    <= '0;
         iss_s2_q    <= '0;
         iss_dst_q   <= '0;
         iss_pay_q   <= '0;
         for (int i = 0; i < RS_ENTRIES; i++) age_q[i] <= '0;
      end else begin
         valid_q     <= valid_d;
         s1_rdy_q    <= s1_rdy_d;
         s2_rdy_q    <= s2_rdy_d;
         occ_q       <= occ_d;
         iss_valid_q <= iss_valid_d;
         iss_s1_q    <= iss_s1_d;
         iss_s2_q    <= iss_s2_d;
         iss_dst_q   <= iss_dst_d;
         iss_pay_q   <= iss_pay_d;
         age_q       <= age_d;
      end
   end

   always_ff @(posedge clk) begin
      s1_tag_q <= s1_tag_d;
      s2_tag_q <= s2_tag_d;
      dst_q    <= dst_d;
      pay_q    <= pay_d;
   end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: vector table for basic issue/wakeup/bypass, plus directed
// sequences for full RS, issue stall with out-of-index age order, flush and reset.
module tb_rs_issue_scheduler;
   localparam int TW = 7;
   localparam int PW = 38;
   localparam logic [30:0] PTAIL = 31'h1234567;

   logic          clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic          disp_valid = 1'b0, disp_ready;
   logic [TW-1:0] disp_src1_tag = '0, disp_src2_tag = '0, disp_dst_tag = '0;
   logic          disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
   logic [PW-1:0] disp_payload = '0;
   logic [1:0]    wb_valid = '0;
   logic [2*TW-1:0] wb_tag = '0;
   logic          iss_valid, iss_ready = 1'b1;
   logic [TW-1:0] iss_src1_tag, iss_src2_tag, iss_dst_tag;
   logic [PW-1:0] iss_payload;
   logic [3:0]    occupancy;
   int            total = 0, bad = 0;

   rs_issue_scheduler dut (
      .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_dst_tag(disp_dst_tag), .disp_payload(disp_payload),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag), .iss_dst_tag(iss_dst_tag),
      .iss_payload(iss_payload), .flush(flush), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic dv; logic [TW-1:0] s1; logic r1; logic [TW-1:0] s2; logic r2; logic [TW-1:0] dst;
      logic [1:0] wbv; logic [TW-1:0] wb0, wb1;
      logic e_iv; logic [TW-1:0] e_dst; logic [3:0] e_occ; logic e_rdy;
   } vec_t;
   vec_t vq[$];

   task automatic add(input bit dv, input int s1, input bit r1, input int s2, input bit r2,
                      input int dst, input int wbv, input int wb0, input int wb1,
                      input bit e_iv, input int e_dst, input int e_occ, input bit e_rdy);
      vec_t v;
      v.dv = dv; v.s1 = TW'(s1); v.r1 = r1; v.s2 = TW'(s2); v.r2 = r2; v.dst = TW'(dst);
      v.wbv = 2'(wbv); v.wb0 = TW'(wb0); v.wb1 = TW'(wb1);
      v.e_iv = e_iv; v.e_dst = TW'(e_dst); v.e_occ = 4'(e_occ); v.e_rdy = e_rdy;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit dv, input int s1, input bit r1, input int s2, input bit r2, input int dst);
      disp_valid = dv; disp_src1_tag = TW'(s1); disp_src1_rdy = r1;
      disp_src2_tag = TW'(s2); disp_src2_rdy = r2; disp_dst_tag = TW'(dst);
      disp_payload = {TW'(dst), PTAIL};
   endtask

   task automatic idle();
      drive(1'b0, 0, 1'b0, 0, 1'b0, 0);
      wb_valid = '0; wb_tag = '0; flush = 1'b0;
   endtask

   task automatic wait_issue(input int d, input string nm, output int cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!iss_valid && cyc < 20);
      chk({nm, " iss_valid"}, 64'(iss_valid), 64'd1);
      chk({nm, " iss_dst"}, 64'(iss_dst_tag), 64'(d));
      chk({nm, " iss_payload"}, 64'(iss_payload), 64'({TW'(d), PTAIL}));
   endtask

   initial begin
      int cyc;
      // table rows: outputs checked first, then the row's inputs applied for the next edge
      add(1, 1,1, 2,1, 5,  0, 0,0,   0,0,0,1);
      add(0, 0,0, 0,0, 0,  0, 0,0,   0,0,1,1);
      add(0, 0,0, 0,0, 0,  0, 0,0,   1,5,0,1);
      add(1, 20,0, 21,1, 7, 2, 0,20, 0,0,0,1);
      add(0, 0,0, 0,0, 0,  0, 0,0,   0,0,1,1);
      add(1, 10,0, 11,1, 1, 0, 0,0,  1,7,0,1);
      add(1, 12,1, 13,1, 2, 0, 0,0,  0,0,1,1);
      add(0, 0,0, 0,0, 0,  1, 10,0,  0,0,2,1);
      add(0, 0,0, 0,0, 0,  0, 0,0,   1,2,1,1);
      add(1, 8,1, 30,0, 3, 0, 0,0,   1,1,0,1);
      add(0, 0,0, 0,0, 0,  0, 30,0,  0,0,1,1);
      add(0, 0,0, 0,0, 0,  1, 31,0,  0,0,1,1);
      add(0, 0,0, 0,0, 0,  2, 0,30,  0,0,1,1);
      add(0, 0,0, 0,0, 0,  0, 0,0,   0,0,1,1);
      add(0, 0,0, 0,0, 0,  0, 0,0,   1,3,0,1);
      add(0, 0,0, 0,0, 0,  0, 0,0,   0,0,0,1);

      idle();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         chk($sformatf("row%0d iss_valid", i), 64'(iss_valid), 64'(vq[i].e_iv));
         chk($sformatf("row%0d occupancy", i), 64'(occupancy), 64'(vq[i].e_occ));
         chk($sformatf("row%0d disp_ready", i), 64'(disp_ready), 64'(vq[i].e_rdy));
         if (vq[i].e_iv) chk($sformatf("row%0d iss_dst", i), 64'(iss_dst_tag), 64'(vq[i].e_dst));
         else if (i == 0) chk("reset iss_dst", 64'(iss_dst_tag), 64'd0);
         drive(vq[i].dv, int'(vq[i].s1), vq[i].r1, int'(vq[i].s2), vq[i].r2, int'(vq[i].dst));
         wb_valid = vq[i].wbv;
         wb_tag = {vq[i].wb1, vq[i].wb0};
      end

      // fill all entries on one unready tag, overflow attempt, then wake everything at once
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         idle();
         drive(1'b1, 40, 1'b0, 40, 1'b0, 10 + k);
      end
      @(negedge clk);
      idle();
      chk("full occupancy", 64'(occupancy), 64'd8);
      chk("full disp_ready", 64'(disp_ready), 64'd0);
      drive(1'b1, 1, 1'b1, 2, 1'b1, 99);
      @(negedge clk);
      idle();
      chk("ignored dispatch occupancy", 64'(occupancy), 64'd8);
      chk("ignored dispatch iss_valid", 64'(iss_valid), 64'd0);
      wb_valid = 2'b01; wb_tag = {TW'(0), TW'(40)};
      @(posedge clk);
      #1 idle();
      for (int k = 0; k < 8; k++) begin
         wait_issue(10 + k, $sformatf("drain%0d", k), cyc);
         if (k > 0) chk($sformatf("drain%0d back-to-back", k), 64'(cyc), 64'd1);
         if (k == 0) chk("drain0 occupancy", 64'(occupancy), 64'd7);
      end
      repeat (3) begin
         @(negedge clk);
         chk("after drain iss_valid", 64'(iss_valid), 64'd0);
         chk("after drain occupancy", 64'(occupancy), 64'd0);
      end

      // stall the FU; a younger uop lands in a lower slot than an older one still waiting
      iss_ready = 1'b0;
      drive(1'b1, 1, 1'b1, 2, 1'b1, 20);
      @(negedge clk); drive(1'b1, 3, 1'b1, 4, 1'b1, 21);
      @(negedge clk); drive(1'b1, 5, 1'b1, 6, 1'b1, 22);
      @(negedge clk); idle();
      for (int h = 0; h < 5; h++) begin
         chk($sformatf("stall%0d iss_valid", h), 64'(iss_valid), 64'd1);
         chk($sformatf("stall%0d iss_dst", h), 64'(iss_dst_tag), 64'd20);
         chk($sformatf("stall%0d iss_src1", h), 64'(iss_src1_tag), 64'd1);
         chk($sformatf("stall%0d iss_src2", h), 64'(iss_src2_tag), 64'd2);
         chk($sformatf("stall%0d occupancy", h), 64'(occupancy), 64'd2);
         @(negedge clk);
      end
      drive(1'b1, 7, 1'b1, 8, 1'b1, 23);
      @(negedge clk);
      idle();
      chk("stall late occupancy", 64'(occupancy), 64'd3);
      chk("stall late iss_dst", 64'(iss_dst_tag), 64'd20);
      iss_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_issue(21 + k, $sformatf("release%0d", k), cyc);
         chk($sformatf("release%0d back-to-back", k), 64'(cyc), 64'd1);
      end
      @(negedge clk);
      chk("release done iss_valid", 64'(iss_valid), 64'd0);

      // flush with a concurrent dispatch
      iss_ready = 1'b0;
      drive(1'b1, 1, 1'b1, 2, 1'b1, 30);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         drive(1'b1, 60, 1'b0, 2, 1'b1, 30 + k);
      end
      @(negedge clk);
      idle();
      chk("pre-flush occupancy", 64'(occupancy), 64'd3);
      chk("pre-flush iss_valid", 64'(iss_valid), 64'd1);
      chk("pre-flush iss_dst", 64'(iss_dst_tag), 64'd30);
      flush = 1'b1;
      drive(1'b1, 1, 1'b1, 2, 1'b1, 77);
      @(negedge clk);
      idle();
      chk("flush occupancy", 64'(occupancy), 64'd0);
      chk("flush iss_valid", 64'(iss_valid), 64'd0);
      chk("flush disp_ready", 64'(disp_ready), 64'd1);
      iss_ready = 1'b1;
      wb_valid = 2'b01; wb_tag = {TW'(0), TW'(60)};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         idle();
         chk($sformatf("post-flush%0d iss_valid", k), 64'(iss_valid), 64'd0);
         chk($sformatf("post-flush%0d occupancy", k), 64'(occupancy), 64'd0);
      end

      // reset mid-operation beats a same-cycle dispatch
      iss_ready = 1'b0;
      drive(1'b1, 1, 1'b1, 2, 1'b1, 44);
      @(negedge clk); drive(1'b1, 3, 1'b1, 4, 1'b1, 45);
      @(negedge clk); idle();
      chk("pre-reset iss_valid", 64'(iss_valid), 64'd1);
      chk("pre-reset occupancy", 64'(occupancy), 64'd1);
      rst = 1'b1;
      drive(1'b1, 5, 1'b1, 6, 1'b1, 46);
      @(negedge clk);
      rst = 1'b0;
      idle();
      iss_ready = 1'b1;
      chk("reset iss_valid", 64'(iss_valid), 64'd0);
      chk("reset occupancy", 64'(occupancy), 64'd0);
      chk("reset disp_ready", 64'(disp_ready), 64'd1);
      chk("reset iss_dst zero", 64'(iss_dst_tag), 64'd0);
      chk("reset iss_src1 zero", 64'(iss_src1_tag), 64'd0);
      chk("reset iss_payload zero", 64'(iss_payload), 64'd0);
      repeat (4) begin
         @(negedge clk);
         chk("post-reset iss_valid", 64'(iss_valid), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rs_issue_scheduler.md
RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 SHALL have parameter RS_ENTRIES, default 8, meaning the number of reservation-station entries.
REQ-002 SHALL have parameter NUM_PREGS, default 128, meaning the physical register count; TAG_W = $clog2(NUM_PREGS).
REQ-003 SHALL have parameter NUM_WB, default 2, meaning the number of writeback tag broadcast ports.
REQ-004 SHALL have parameter PAYLOAD_W, default 38, meaning the opaque opcode+immediate width.
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-006 SHALL have rst  in  1  synchronous active-high reset.
REQ-007 SHALL have disp_valid  in  1  dispatch request.
REQ-008 SHALL have disp_ready  out  1  at least one free entry.
REQ-009 SHALL have disp_src1_tag and disp_src2_tag  in  TAG_W each  source physical tags.
REQ-010 SHALL have disp_src1_rdy and disp_src2_rdy  in  1 each  source already available.
REQ-011 SHALL have disp_dst_tag  in  TAG_W  destination tag, and disp_payload  in  PAYLOAD_W  opcode/immediate.
REQ-012 SHALL have wb_valid  in  NUM_WB and wb_tag  in  NUM_WB*TAG_W  wakeup broadcasts.
REQ-013 SHALL have iss_valid  out  1 and iss_ready  in  1  issue handshake to the FU.
REQ-014 SHALL have iss_src1_tag, iss_src2_tag, iss_dst_tag  out  TAG_W each, and iss_payload  out  PAYLOAD_W.
REQ-015 SHALL have flush  in  1  discard all contents, and occupancy  out  $clog2(RS_ENTRIES)+1  valid entries held.

Function
REQ-016 Each entry SHALL hold: valid, src1/src2 tags, src1/src2 ready bits, dst tag, payload, and an age relation to every other entry (age matrix).
REQ-017 A dispatch SHALL be accepted when disp_valid && disp_ready; it writes the lowest-index free entry at the clock edge.
REQ-018 disp_ready SHALL equal (occupancy < RS_ENTRIES), using registered state only; an entry freed in the same cycle does not raise disp_ready until the next cycle.
REQ-019 A wakeup SHALL set an entry's src ready bit at the edge when any wb_valid[i] is high with wb_tag[i] equal to that entry's src tag.
REQ-020 Same-cycle bypass: an accepted dispatch SHALL store src ready = disp_srcN_rdy OR a match against any valid wb_tag in that cycle.
REQ-021 An entry SHALL be eligible when valid and both src ready bits are set from registered state; a wakeup at edge T makes the entry eligible in cycle T+1.
REQ-022 Select SHALL choose the oldest eligible entry (earliest accepted dispatch) as determined by the age matrix.
REQ-023 The issue register SHALL load the selected entry, and that entry SHALL be freed at the same edge, when the issue register is empty or iss_valid && iss_ready.
REQ-024 iss_* outputs SHALL be driven only from the issue register, and SHALL remain stable while iss_valid && !iss_ready.
REQ-025 Minimum latency: dispatch with both sources ready is accepted at edge T; iss_valid is high in cycle T+2.
REQ-026 With continuous eligible entries and iss_ready held high, throughput SHALL be one issue per cycle.
REQ-027 Dispatch, wakeup, select and issue SHALL all be allowed to occur in the same cycle without loss or duplication.
REQ-028 occupancy SHALL count valid RS entries only, excluding the issue register, and SHALL be updated as +accept −select each edge.
REQ-029 flush SHALL clear all entries, the age matrix, and the issue register at the edge; flush has priority over dispatch, and any dispatch in the flush cycle is dropped.
REQ-030 Dispatch when disp_ready is low SHALL be ignored with no state change.

Reset
REQ-031 While rst is high at a clock edge, all entries SHALL be invalidated, the issue register emptied, iss_valid=0, occupancy=0, and disp_ready=1 in the following cycle.
REQ-032 rst SHALL take priority over flush, dispatch, wakeup and issue; a reset mid-operation discards all held uops.
REQ-033 iss_* data outputs SHALL read 0 after reset.

Verification
REQ-034 Dispatch one uop with both srcs ready (dst=5) at edge 0, iss_ready=1 -> iss_valid=1 with iss_dst_tag=5 in cycle 2, occupancy back to 0.
REQ-035 Dispatch A (src1=10 not ready), then B (ready), then wb tag 10 -> B issues first; A issues the cycle after B.
REQ-036 Dispatch 8 uops with no sources ready -> disp_ready=0, occupancy=8; a 9th dispatch is ignored; wake all -> 8 issues in dispatch order.
REQ-037 Hold iss_ready=0 for 5 cycles with 3 eligible entries -> iss outputs stay constant, occupancy=2; release -> remaining entries issue oldest-first.
REQ-038 Dispatch src1=20 not ready in the same cycle as wb_tag=20 -> entry is eligible next cycle; iss_valid two cycles after dispatch.
REQ-039 Fill 4 entries, assert flush together with a dispatch -> next cycle occupancy=0, iss_valid=0; the dispatched uop never issues.
